// File: rtl/riscv_ifu_fetch.sv
// Instruction-fetch stage: one outstanding memory request, small {pc, inst, fault} buffer, valid/ready to decode.
// Optional feature macro IFU_BYPASS_EN: a response arriving with an empty buffer is shown on out_* in the same cycle.
module riscv_ifu_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h8000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        mem_rsp_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        out_fault
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2,
      ST_HALT = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic             started_q;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [31:0]      pc_mem    [BUF_DEPTH];
   logic [31:0]      inst_mem  [BUF_DEPTH];
   logic             fault_mem [BUF_DEPTH];

   logic             req_fire;
   logic             rsp_take;
   logic             fifo_valid;
   logic             push;
   logic             pop;
   logic             bypass_sel;
   logic [31:0]      rsp_inst;
   logic             unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // started_q keeps the request line low until the first edge after reset release
   assign mem_req_valid = started_q && (state_q == ST_REQ) && (count_q < DEPTH_CNT);
   assign mem_req_addr  = fetch_pc_q;
   assign req_fire      = mem_req_valid && mem_req_ready;

   // A response is kept only while waiting for it and not overtaken by a redirect
   assign rsp_take   = (state_q == ST_WAIT) && mem_rsp_valid && !redirect_valid;
   assign rsp_inst   = mem_rsp_err ? NOP_INST : mem_rsp_data;
   assign fifo_valid = (count_q != '0);
   assign pop        = fifo_valid && out_ready;

`ifdef IFU_BYPASS_EN
   assign bypass_sel = rsp_take && (count_q == '0);
`else
   assign bypass_sel = 1'b0;
`endif

   assign push      = rsp_take && !(bypass_sel && out_ready);
   assign out_valid = fifo_valid || bypass_sel;

   always_comb begin
      out_pc    = '0;
      out_inst  = '0;
      out_fault = 1'b0;
      if (fifo_valid) begin
         out_pc    = pc_mem[rd_ptr_q];
         out_inst  = inst_mem[rd_ptr_q];
         out_fault = fault_mem[rd_ptr_q];
      end else if (bypass_sel) begin
         out_pc    = fetch_pc_q;
         out_inst  = rsp_inst;
         out_fault = mem_rsp_err;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      case (state_q)
         ST_REQ: begin
            if (req_fire) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rsp_valid) begin
               if (mem_rsp_err) begin
                  state_d = ST_HALT;
               end else begin
                  state_d    = ST_REQ;
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end
            end
         end
         ST_DROP: begin
            if (mem_rsp_valid) state_d = ST_REQ;
         end
         default: state_d = ST_HALT;
      endcase
      // A redirect overrides everything; DROP only if a response is still owed to us
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         if (req_fire ||
             ((state_q == ST_WAIT) && !mem_rsp_valid) ||
             ((state_q == ST_DROP) && !mem_rsp_valid)) begin
            state_d = ST_DROP;
         end else begin
            state_d = ST_REQ;
         end
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (redirect_valid) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_REQ;
         fetch_pc_q <= RESET_PC;
         started_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         started_q  <= 1'b1;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: outputs are gated by count
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= fetch_pc_q;
         inst_mem[wr_ptr_q]  <= rsp_inst;
         fault_mem[wr_ptr_q] <= mem_rsp_err;
      end
   end

endmodule

// File: tb/tb_riscv_ifu_fetch.sv
// Scoreboard bench for riscv_ifu_fetch: directed test-plan scenarios followed by randomized traffic.
module tb_riscv_ifu_fetch;

   localparam logic [31:0] RESET_PC  = 32'h8000_0000;
   localparam int          BUF_DEPTH = 2;
   localparam logic [31:0] NOP       = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        mem_rsp_err = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_fault;

   always #5 clk = ~clk;

   riscv_ifu_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } ent_t;

   ent_t        sb[$];
   logic [31:0] req_log[$];
   logic [31:0] out_log[$];
   logic        fault_log[$];
   int          vectors = 0;
   int          miscompares = 0;

   // memory model and reference fetch model
   logic        mem_busy = 1'b0;
   logic        mem_stale = 1'b0;
   logic [31:0] mem_addr = '0;
   int          mem_delay = 0;
   int          fixed_delay = 0;
   logic [31:0] err_addr = 32'h1;
   logic        rand_err_en = 1'b0;
   logic [31:0] exp_pc = RESET_PC;
   logic        halted = 1'b0;
   logic        hold_valid = 1'b0;
   logic [31:0] hold_addr = '0;
   ent_t        mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   function automatic logic [31:0] get_req(input int i);
      return (i >= 0 && i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] get_out(input int i);
      return (i >= 0 && i < out_log.size()) ? out_log[i] : 32'hDEAD_BEEF;
   endfunction

   // One clock cycle: drive at negedge, evaluate the model 1 ns later, flush after the monitor ran
   task automatic cycle(input logic ordy, input logic mrdy, input logic redir, input logic [31:0] rpc);
      logic [31:0] rdata;
      logic        rerr;
      logic        rsp;
      logic        fire;
      @(negedge clk);
      out_ready      = ordy;
      mem_req_ready  = mrdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      rsp   = mem_busy && (mem_delay == 0);
      rdata = $urandom;
      rerr  = rsp ? ((mem_addr == err_addr) || (rand_err_en && mem_addr[7:2] == 6'h2B))
                  : 1'($urandom_range(0, 1));
      mem_rsp_valid = rsp;
      mem_rsp_data  = rdata;
      mem_rsp_err   = rerr;
      #1;
      chk("out_valid_vs_model", 32'(out_valid), 32'(sb.size() != 0));
      if (sb.size() >= BUF_DEPTH || halted)
         chk("req_blocked", 32'(mem_req_valid), 32'd0);
      if (hold_valid) begin
         chk("req_valid_held", 32'(mem_req_valid), 32'd1);
         chk("req_addr_held", mem_req_addr, hold_addr);
      end
      hold_valid = mem_req_valid && !mrdy && !redir;
      hold_addr  = mem_req_addr;
      fire = mem_req_valid && mrdy;
      if (fire) begin
         chk("req_addr", mem_req_addr, exp_pc);
         chk("req_single_outstanding", 32'(mem_busy), 32'd0);
      end
      if (rsp) begin
         if (!mem_stale && !redir) begin
            sb.push_back('{pc: mem_addr, inst: (rerr ? NOP : rdata), fault: rerr});
            if (rerr) halted = 1'b1;
            else      exp_pc = mem_addr + 32'd4;
         end
         mem_busy = 1'b0;
      end else if (mem_busy) begin
         mem_delay--;
      end
      if (fire) begin
         mem_busy  = 1'b1;
         mem_addr  = mem_req_addr;
         mem_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
         mem_stale = redir;
         req_log.push_back(mem_req_addr);
      end
      if (redir) begin
         exp_pc = rpc & ~32'h3;
         halted = 1'b0;
         if (mem_busy) mem_stale = 1'b1;
      end
      #3;
      if (redir) sb.delete();
   endtask

   task automatic run(input int n, input logic ordy, input logic mrdy);
      for (int i = 0; i < n; i++) cycle(ordy, mrdy, 1'b0, 32'h0);
   endtask

   // Monitor: pops the scoreboard on every output handshake
   always begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_out: got pc %h with no entry expected", out_pc);
         end else begin
            mon_e = sb.pop_front();
            chk("out_pc", out_pc, mon_e.pc);
            chk("out_inst", out_inst, mon_e.inst);
            chk("out_fault", 32'(out_fault), 32'(mon_e.fault));
         end
         out_log.push_back(out_pc);
         fault_log.push_back(out_fault);
         $display("txn pc=%h inst=%h fault=%0b", out_pc, out_inst, out_fault);
      end
   end

   initial begin
      int r;
      int o;
      int n;
      logic [31:0] a0;
      logic [31:0] rpc;
      logic redir;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_req_addr", mem_req_addr, RESET_PC);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_out_fault", 32'(out_fault), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("req_valid_before_first_edge", 32'(mem_req_valid), 32'd0);

      // Sequential fetch with a 1-cycle memory
      fixed_delay = 0;
      run(12, 1'b1, 1'b1);
      chk("t1_req0", get_req(0), 32'h8000_0000);
      chk("t1_req1", get_req(1), 32'h8000_0004);
      chk("t1_req2", get_req(2), 32'h8000_0008);
      chk("t1_out0", get_out(0), 32'h8000_0000);
      chk("t1_out1", get_out(1), 32'h8000_0004);
      chk("t1_out2", get_out(2), 32'h8000_0008);

      // Decode stalled: buffer fills to BUF_DEPTH and requests stop
      cycle(1'b0, 1'b1, 1'b1, RESET_PC);
      r = req_log.size();
      run(10, 1'b0, 1'b1);
      chk("t2_req_count", 32'(req_log.size() - r), 32'd2);
      chk("t2_out_valid", 32'(out_valid), 32'd1);
      chk("t2_req_valid", 32'(mem_req_valid), 32'd0);
      chk("t2_head_pc", out_pc, 32'h8000_0000);
      r = req_log.size();
      o = out_log.size();
      run(6, 1'b1, 1'b1);
      chk("t2_drain0", get_out(o), 32'h8000_0000);
      chk("t2_drain1", get_out(o + 1), 32'h8000_0004);
      chk("t2_resume", get_req(r), 32'h8000_0008);

      // Redirect while waiting on a slow response
      fixed_delay = 2;
      run(10, 1'b1, 1'b1);
      r = req_log.size();
      n = 0;
      while (req_log.size() == r && n < 20) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         n++;
      end
      chk("t3_fire_seen", 32'(req_log.size() > r), 32'd1);
      cycle(1'b1, 1'b1, 1'b1, 32'h8000_0102);
      r = req_log.size();
      o = out_log.size();
      n = 0;
      while (out_log.size() == o && n < 30) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         n++;
      end
      chk("t3_next_req", get_req(r), 32'h8000_0100);
      chk("t3_next_out", get_out(o), 32'h8000_0100);

      // Access fault halts fetching until a redirect
      fixed_delay = 0;
      err_addr = 32'h8000_0010;
      cycle(1'b1, 1'b1, 1'b1, RESET_PC);
      run(20, 1'b1, 1'b1);
      chk("t4_fault_pc", get_out(out_log.size() - 1), 32'h8000_0010);
      chk("t4_fault_flag", 32'(fault_log.size() > 0 && fault_log[fault_log.size() - 1]), 32'd1);
      r = req_log.size();
      run(8, 1'b1, 1'b1);
      chk("t4_no_req_halted", 32'(req_log.size()), 32'(r));
      err_addr = 32'h1;
      cycle(1'b1, 1'b1, 1'b1, RESET_PC);
      run(4, 1'b1, 1'b1);
      chk("t4_resume", get_req(r), RESET_PC);

      // Memory not ready for 5 cycles: address held, nothing accepted
      run(4, 1'b1, 1'b1);
      run(2, 1'b1, 1'b0);
      a0 = mem_req_addr;
      r = req_log.size();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 32'h0);
         chk("t5_valid", 32'(mem_req_valid), 32'd1);
         chk("t5_addr", mem_req_addr, a0);
      end
      chk("t5_no_accept", 32'(req_log.size()), 32'(r));
      run(6, 1'b1, 1'b1);
      chk("t5_accepted_addr", get_req(r), a0);

      // Redirect with an output handshake while the buffer is full
      n = 0;
      while (sb.size() < BUF_DEPTH && n < 20) begin
         cycle(1'b0, 1'b1, 1'b0, 32'h0);
         n++;
      end
      o = out_log.size();
      cycle(1'b1, 1'b1, 1'b1, 32'h8000_0200);
      chk("t6_consumed_once", 32'(out_log.size()), 32'(o + 1));
      r = req_log.size();
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("t6_empty_after", 32'(out_valid), 32'd0);
      run(4, 1'b1, 1'b1);
      chk("t6_restart_req", get_req(r), 32'h8000_0200);
      chk("t6_restart_out", get_out(o + 1), 32'h8000_0200);

      // Randomized traffic, including faults and redirects near the address wrap
      fixed_delay = -1;
      rand_err_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         redir = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
         case ($urandom_range(0, 2))
            0:       rpc = 32'h8000_0000 + $urandom_range(0, 255);
            1:       rpc = 32'hFFFF_FFE0 + $urandom_range(0, 31);
            default: rpc = $urandom;
         endcase
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), redir, rpc);
      end
      run(20, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
